// File: rtl/cvxif_copro_resp.sv
// CV-X-IF coprocessor responder: decodes custom-3 instructions, keeps them in an
// in-order in-flight queue, executes at the head and returns results under commit/kill.
module cvxif_copro_resp #(
  parameter int X_NUM_RS      = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 32,
  parameter int QUEUE_DEPTH   = 4,
  parameter int MULTI_LAT     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_issue_valid_i,
  output logic                       x_issue_ready_o,
  input  logic [31:0]                x_issue_instr_i,
  input  logic [TRANS_ID_BITS-1:0]   x_issue_id_i,
  input  logic [X_NUM_RS*XLEN-1:0]   x_issue_rs_i,
  input  logic [X_NUM_RS-1:0]        x_issue_rs_valid_i,
  output logic                       x_issue_accept_o,
  output logic                       x_issue_writeback_o,
  input  logic                       x_commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   x_commit_id_i,
  input  logic                       x_commit_kill_i,
  output logic                       x_result_valid_o,
  input  logic                       x_result_ready_i,
  output logic [TRANS_ID_BITS-1:0]   x_result_id_o,
  output logic [XLEN-1:0]            x_result_data_o,
  output logic [4:0]                 x_result_rd_o,
  output logic                       x_result_we_o,
  output logic                       x_result_exc_o,
  output logic [5:0]                 x_result_exccode_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(MULTI_LAT) + 1;

  typedef enum logic [1:0] {OP_ADD, OP_MULTI, OP_EXC, OP_NOP} op_e;

  logic [PW-1:0]            head_q, tail_q;
  logic [CW-1:0]            count_q;
  logic [LW-1:0]            cnt_q, cnt_d;
  logic                     vld_q  [QUEUE_DEPTH];
  logic                     cmt_q  [QUEUE_DEPTH];
  logic                     kill_q [QUEUE_DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q   [QUEUE_DEPTH];
  logic [4:0]               rd_q   [QUEUE_DEPTH];
  logic [4:0]               excf_q [QUEUE_DEPTH];
  op_e                      op_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]          rs1_q  [QUEUE_DEPTH];
  logic [XLEN-1:0]          rs2_q  [QUEUE_DEPTH];

  logic                     res_valid_q, res_we_q, res_exc_q;
  logic [TRANS_ID_BITS-1:0] res_id_q;
  logic [XLEN-1:0]          res_data_q;
  logic [4:0]               res_rd_q;
  logic [5:0]               res_exccode_q;

  logic dec_ok, dec_wb, push, pop, drop, retire, head_vld, head_done, res_take, new_cmt;
  op_e  dec_op;
  logic unused_instr_bits;

  assign unused_instr_bits = ^x_issue_instr_i[19:15];

  always_comb begin
    dec_ok = 1'b0;
    dec_wb = 1'b0;
    dec_op = OP_NOP;
    if (x_issue_instr_i[6:0] == 7'h7B && x_issue_instr_i[14:12] == 3'b000) begin
      case (x_issue_instr_i[31:25])
        7'h00:   begin dec_ok = 1'b1; dec_wb = 1'b1; dec_op = OP_ADD;   end
        7'h01:   begin dec_ok = 1'b1; dec_wb = 1'b1; dec_op = OP_MULTI; end
        7'h02:   begin dec_ok = 1'b1; dec_wb = 1'b0; dec_op = OP_EXC;   end
        7'h03:   begin dec_ok = 1'b1; dec_wb = 1'b0; dec_op = OP_NOP;   end
        default: begin dec_ok = 1'b0; dec_wb = 1'b0; dec_op = OP_NOP;   end
      endcase
    end else begin
      dec_ok = 1'b0;
    end
  end

  // Ready looks only at the registered count, so a same-cycle retire cannot reopen it.
  assign x_issue_ready_o     = !rst_i && (count_q != CW'(QUEUE_DEPTH)) && (&x_issue_rs_valid_i);
  assign push                = x_issue_valid_i && x_issue_ready_o && dec_ok;
  assign x_issue_accept_o    = push;
  assign x_issue_writeback_o = push && dec_wb;
  assign new_cmt             = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);

  assign head_vld  = (count_q != '0);
  assign head_done = head_vld && (op_q[head_q] != OP_MULTI || cnt_q == LW'(MULTI_LAT - 1));
  assign res_take  = res_valid_q && x_result_ready_i;
  assign drop      = head_vld && kill_q[head_q];
  assign retire    = head_done && cmt_q[head_q] && !kill_q[head_q] && (!res_valid_q || res_take);
  assign pop       = drop || retire;

  always_comb begin
    cnt_d = cnt_q;
    if (pop || !head_vld) begin
      cnt_d = '0;
    end else if (cnt_q != LW'(MULTI_LAT - 1)) begin
      cnt_d = cnt_q + LW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        cmt_q[i]  <= 1'b0;
        kill_q[i] <= 1'b0;
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        excf_q[i] <= '0;
        op_q[i]   <= OP_NOP;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (x_commit_valid_i && vld_q[i] && id_q[i] == x_commit_id_i) begin
          if (x_commit_kill_i) kill_q[i] <= 1'b1;
          else                 cmt_q[i]  <= 1'b1;
        end
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      // A commit for the id being issued this cycle lands on the new entry.
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        cmt_q[tail_q]  <= new_cmt && !x_commit_kill_i;
        kill_q[tail_q] <= new_cmt && x_commit_kill_i;
        id_q[tail_q]   <= x_issue_id_i;
        rd_q[tail_q]   <= x_issue_instr_i[11:7];
        excf_q[tail_q] <= x_issue_instr_i[24:20];
        op_q[tail_q]   <= dec_op;
        rs1_q[tail_q]  <= x_issue_rs_i[XLEN-1:0];
        rs2_q[tail_q]  <= x_issue_rs_i[2*XLEN-1:XLEN];
        tail_q         <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_we_q      <= 1'b0;
      res_exc_q     <= 1'b0;
      res_exccode_q <= '0;
    end else if (retire) begin
      res_valid_q   <= 1'b1;
      res_id_q      <= id_q[head_q];
      res_rd_q      <= rd_q[head_q];
      res_we_q      <= (op_q[head_q] == OP_ADD) || (op_q[head_q] == OP_MULTI);
      res_data_q    <= ((op_q[head_q] == OP_ADD) || (op_q[head_q] == OP_MULTI)) ?
                       (rs1_q[head_q] + rs2_q[head_q]) : '0;
      res_exc_q     <= (op_q[head_q] == OP_EXC);
      res_exccode_q <= (op_q[head_q] == OP_EXC) ? {1'b0, excf_q[head_q]} : 6'd0;
    end else if (res_take) begin
      res_valid_q   <= 1'b0;
    end else begin
      res_valid_q   <= res_valid_q;
    end
  end

  assign x_result_valid_o   = res_valid_q;
  assign x_result_id_o      = res_id_q;
  assign x_result_data_o    = res_data_q;
  assign x_result_rd_o      = res_rd_q;
  assign x_result_we_o      = res_we_q;
  assign x_result_exc_o     = res_exc_q;
  assign x_result_exccode_o = res_exccode_q;
  assign busy_o             = head_vld || res_valid_q;

endmodule

// File: tb/tb_cvxif_copro_resp.sv
// Directed bench for cvxif_copro_resp: expected results are queued at issue time
// and compared against every result handshake; latency and flow control checked inline.
module tb_cvxif_copro_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, accept, writeback;
  logic [31:0] instr;
  logic [2:0]  issue_id;
  logic [63:0] rs;
  logic [1:0]  rs_valid;
  logic        commit_valid, commit_kill;
  logic [2:0]  commit_id;
  logic        res_valid, res_ready, res_we, res_exc, busy;
  logic [2:0]  res_id;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [5:0]  res_exccode;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  code;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  cvxif_copro_resp dut (
    .clk_i(clk), .rst_i(rst),
    .x_issue_valid_i(issue_valid), .x_issue_ready_o(issue_ready),
    .x_issue_instr_i(instr), .x_issue_id_i(issue_id),
    .x_issue_rs_i(rs), .x_issue_rs_valid_i(rs_valid),
    .x_issue_accept_o(accept), .x_issue_writeback_o(writeback),
    .x_commit_valid_i(commit_valid), .x_commit_id_i(commit_id), .x_commit_kill_i(commit_kill),
    .x_result_valid_o(res_valid), .x_result_ready_i(res_ready),
    .x_result_id_o(res_id), .x_result_data_o(res_data), .x_result_rd_o(res_rd),
    .x_result_we_o(res_we), .x_result_exc_o(res_exc), .x_result_exccode_o(res_exccode),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2f, input logic [4:0] rd);
    return {f7, rs2f, 5'd1, 3'b000, rd, 7'h7B};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [31:0] ins, input logic [2:0] tid,
                             input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1; instr = ins; issue_id = tid; rs = {b, a}; rs_valid = 2'b11;
  endtask

  task automatic drive_commit(input logic [2:0] tid, input logic k);
    commit_valid = 1'b1; commit_id = tid; commit_kill = k;
  endtask

  task automatic push_exp(input logic [2:0] tid, input logic [31:0] d, input logic [4:0] rd,
                          input logic we, input logic exc, input logic [5:0] code);
    exp_t e;
    e.id = tid; e.data = d; e.rd = rd; e.we = we; e.exc = exc; e.code = code;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      exp_t e;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_result: observed id %0h expected none", res_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res_id", {61'd0, res_id}, {61'd0, e.id});
        check("res_data", {32'd0, res_data}, {32'd0, e.data});
        check("res_rd", {59'd0, res_rd}, {59'd0, e.rd});
        check("res_we", {63'd0, res_we}, {63'd0, e.we});
        check("res_exc", {63'd0, res_exc}, {63'd0, e.exc});
        check("res_exccode", {58'd0, res_exccode}, {58'd0, e.code});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, held;
    rst = 1'b0; issue_valid = 1'b0; instr = 32'd0; issue_id = 3'd0; rs = 64'd0;
    rs_valid = 2'b00; commit_valid = 1'b0; commit_id = 3'd0; commit_kill = 1'b0;
    res_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // CUS_ADD id=2, committed same cycle, modulo sum.
    a = 32'h0000_0005; b = 32'hFFFF_FFFE;
    drive_issue(mk(7'h00, 5'd2, 5'd10), 3'd2, a, b);
    drive_commit(3'd2, 1'b0);
    #1;
    check("add_ready", {63'd0, issue_ready}, 64'd1);
    check("add_accept", {63'd0, accept}, 64'd1);
    check("add_wb", {63'd0, writeback}, 64'd1);
    push_exp(3'd2, a + b, 5'd10, 1'b1, 1'b0, 6'd0);
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    #1 check("add_lat_n1", {63'd0, res_valid}, 64'd0);
    tick();
    check("add_lat_n2", {63'd0, res_valid}, 64'd1);
    check("add_data_n2", {32'd0, res_data}, 64'h3);
    tick();
    wait_idle(10);

    // CUS_ADD_MULTI id=4, commit two cycles late, back-pressure for 3 cycles.
    res_ready = 1'b0;
    a = 32'h8000_1234; b = 32'h9000_0010;
    drive_issue(mk(7'h01, 5'd0, 5'd3), 3'd4, a, b);
    #1 check("multi_accept", {62'd0, accept, writeback}, 64'd3);
    push_exp(3'd4, a + b, 5'd3, 1'b1, 1'b0, 6'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    drive_commit(3'd4, 1'b0);
    tick();
    commit_valid = 1'b0;
    tick();
    check("multi_lat_n4", {63'd0, res_valid}, 64'd0);
    tick();
    check("multi_lat_n5", {63'd0, res_valid}, 64'd1);
    check("multi_data", {32'd0, res_data}, {32'd0, a + b});
    held = res_data;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_valid", {63'd0, res_valid}, 64'd1);
      check("hold_data", {32'd0, res_data}, {32'd0, held});
      check("hold_id", {61'd0, res_id}, 64'd4);
    end
    res_ready = 1'b1;
    tick();
    check("multi_consumed", {63'd0, res_valid}, 64'd0);
    wait_idle(10);

    // Kill CUS_ADD_MULTI id=1 mid-execution, then CUS_ADD id=3.
    drive_issue(mk(7'h01, 5'd0, 5'd4), 3'd1, 32'd11, 32'd22);
    tick();
    issue_valid = 1'b0;
    tick();
    drive_commit(3'd1, 1'b1);
    tick();
    a = 32'h0000_0100; b = 32'h0000_0023;
    drive_issue(mk(7'h00, 5'd0, 5'd6), 3'd3, a, b);
    drive_commit(3'd3, 1'b0);
    #1 check("kill_add_accept", {63'd0, accept}, 64'd1);
    push_exp(3'd3, a + b, 5'd6, 1'b1, 1'b0, 6'd0);
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    wait_idle(20);

    // CUS_EXC with cause field 2.
    drive_issue(mk(7'h02, 5'd2, 5'd7), 3'd5, 32'd1, 32'd2);
    drive_commit(3'd5, 1'b0);
    #1;
    check("exc_accept", {63'd0, accept}, 64'd1);
    check("exc_wb", {63'd0, writeback}, 64'd0);
    push_exp(3'd5, 32'd0, 5'd7, 1'b0, 1'b1, 6'd2);
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    wait_idle(10);

    // Operand-valid gating on an empty queue.
    drive_issue(mk(7'h00, 5'd0, 5'd1), 3'd0, 32'd1, 32'd1);
    rs_valid = 2'b01;
    #1;
    check("rsvalid_ready", {63'd0, issue_ready}, 64'd0);
    check("rsvalid_accept", {63'd0, accept}, 64'd0);
    issue_valid = 1'b0;
    tick();

    // Fill the queue, with an unknown opcode slipped in before the last slot.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        drive_issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33}, 3'd6, 32'd5, 32'd5);
        #1;
        check("unknown_ready", {63'd0, issue_ready}, 64'd1);
        check("unknown_accept", {62'd0, accept, writeback}, 64'd0);
        tick();
      end
      a = 32'hF000_0000 + 32'(i); b = 32'h2000_0000 * 32'(i + 1);
      drive_issue(mk(7'h00, 5'd0, 5'(i + 12)), 3'(i), a, b);
      #1 check("fill_accept", {63'd0, accept}, 64'd1);
      push_exp(3'(i), a + b, 5'(i + 12), 1'b1, 1'b0, 6'd0);
      tick();
    end
    issue_valid = 1'b0;
    #1;
    check("full_ready", {63'd0, issue_ready}, 64'd0);
    check("full_busy", {63'd0, busy}, 64'd1);
    drive_issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33}, 3'd6, 32'd5, 32'd5);
    #1 check("full_unknown_accept", {63'd0, accept}, 64'd0);
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_commit(3'(i), 1'b0);
      tick();
    end
    commit_valid = 1'b0;
    wait_idle(40);

    // Reset in the middle of a CUS_ADD_MULTI.
    drive_issue(mk(7'h01, 5'd0, 5'd8), 3'd6, 32'd40, 32'd2);
    drive_commit(3'd6, 1'b0);
    tick();
    commit_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, issue_ready}, 64'd0);
    check("midrst_accept", {62'd0, accept, writeback}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_res", {res_valid, res_we, res_exc, res_exccode, res_id, res_rd, res_data},
          64'd0);
    repeat (3) tick();
    check("midrst_ready_hold", {63'd0, issue_ready}, 64'd0);
    issue_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("postrst_busy", {63'd0, busy}, 64'd0);
    repeat (8) tick();
    check("postrst_res_valid", {63'd0, res_valid}, 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
